// File: rtl/icache_line_unpacker.sv
// I-cache line unpacker: takes whole I-cache lines (two-slot buffer: head + backup)
// and emits them one instruction per cycle with the matching PC.
// Optional feature macro: ICACHE_UNPACK_PERF_CNT_EN adds a 32-bit instruction
// transfer counter output instr_cnt_o.
module icache_line_unpacker #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned ILEN       = 32,
  parameter int unsigned LINE_INSTR = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       line_valid_i,
  output logic                       line_ready_o,
  input  logic [XLEN-1:0]            line_pc_i,
  input  logic [LINE_INSTR*ILEN-1:0] line_data_i,
  input  logic                       flush_i,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic [ILEN-1:0]            instr_o,
  output logic [XLEN-1:0]            pc_o
`ifdef ICACHE_UNPACK_PERF_CNT_EN
  ,
  output logic [31:0]                instr_cnt_o
`endif
);

  localparam int unsigned IDX      = $clog2(LINE_INSTR);
  localparam int unsigned OFFSET   = $clog2(ILEN / 8);
  localparam int unsigned LINE_LEN = LINE_INSTR * ILEN;
  localparam logic [ILEN-1:0] Nop  = ILEN'(32'h0000_0013);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e              state_q, state_d;
  logic [IDX-1:0]      idx_q, idx_d;
  logic [LINE_LEN-1:0] head_data_q, head_data_d;
  logic [XLEN-1:0]     head_base_q, head_base_d;
  logic [LINE_LEN-1:0] backup_data_q, backup_data_d;
  logic [XLEN-1:0]     backup_base_q, backup_base_d;
  logic [IDX-1:0]      backup_idx_q, backup_idx_d;
  logic [ILEN-1:0]     instr_q, instr_d;
  logic [XLEN-1:0]     pc_q, pc_d;

  logic            instr_fire;
  logic            line_fire;
  logic            retire;
  logic [XLEN-1:0] line_base;
  logic [IDX-1:0]  line_idx;

  // Handshakes and decoded capture fields of the incoming line
  always_comb begin
    instr_valid_o = (state_q != StEmpty);
    instr_fire    = instr_valid_o && instr_ready_i;
    retire        = instr_fire && (idx_q == IDX'(LINE_INSTR - 1));
    // A full buffer can still take a line in the cycle its head retires
    line_ready_o  = !flush_i && ((state_q != StTwo) || retire);
    line_fire     = line_valid_i && line_ready_o;
    line_idx      = line_pc_i[OFFSET +: IDX];
    line_base     = line_pc_i;
    line_base[OFFSET+IDX-1:0] = '0;
  end

  // Slot occupancy, head index and next registered instruction/PC
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    head_data_d   = head_data_q;
    head_base_d   = head_base_q;
    backup_data_d = backup_data_q;
    backup_base_d = backup_base_q;
    backup_idx_d  = backup_idx_q;
    instr_d       = Nop;
    pc_d          = '0;

    if (flush_i) begin
      state_d = StEmpty;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (line_fire) begin
            head_data_d = line_data_i;
            head_base_d = line_base;
            idx_d       = line_idx;
            state_d     = StOne;
          end
        end
        StOne: begin
          if (retire) begin
            if (line_fire) begin
              head_data_d = line_data_i;
              head_base_d = line_base;
              idx_d       = line_idx;
            end else begin
              idx_d   = '0;
              state_d = StEmpty;
            end
          end else begin
            if (instr_fire) idx_d = idx_q + IDX'(1);
            if (line_fire) begin
              backup_data_d = line_data_i;
              backup_base_d = line_base;
              backup_idx_d  = line_idx;
              state_d       = StTwo;
            end
          end
        end
        StTwo: begin
          if (retire) begin
            head_data_d = backup_data_q;
            head_base_d = backup_base_q;
            idx_d       = backup_idx_q;
            if (line_fire) begin
              backup_data_d = line_data_i;
              backup_base_d = line_base;
              backup_idx_d  = line_idx;
            end else begin
              state_d = StOne;
            end
          end else if (instr_fire) begin
            idx_d = idx_q + IDX'(1);
          end
        end
        default: begin
          state_d = StEmpty;
          idx_d   = '0;
        end
      endcase
    end

    // Precompute the next head word so instr_o/pc_o are plain flops
    if (state_d != StEmpty) begin
      for (int unsigned k = 0; k < LINE_INSTR; k++) begin
        if (idx_d == IDX'(k)) instr_d = head_data_d[k*ILEN +: ILEN];
      end
      pc_d = head_base_d + (XLEN'(idx_d) << OFFSET);
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      idx_q   <= '0;
      instr_q <= Nop;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  // Line payload storage; contents are only meaningful while the slot is occupied
  always_ff @(posedge clk_i) begin
    head_data_q   <= head_data_d;
    head_base_q   <= head_base_d;
    backup_data_q <= backup_data_d;
    backup_base_q <= backup_base_d;
    backup_idx_q  <= backup_idx_d;
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;

`ifdef ICACHE_UNPACK_PERF_CNT_EN
  logic [31:0] cnt_q;

  // Instruction transfer counter; survives flushes, wraps naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (instr_fire && !flush_i) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign instr_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_icache_line_unpacker.sv
// Directed bench for icache_line_unpacker with a scoreboard of expected {pc, instr}.
module tb_icache_line_unpacker;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int LI   = 32;

  logic              clk;
  logic              rst;
  logic              line_valid;
  logic              line_ready;
  logic [XLEN-1:0]   line_pc;
  logic [LI*ILEN-1:0] line_data;
  logic              flush;
  logic              instr_valid;
  logic              instr_ready;
  logic [ILEN-1:0]   instr;
  logic [XLEN-1:0]   pc;
`ifdef ICACHE_UNPACK_PERF_CNT_EN
  logic [31:0]       instr_cnt;
`endif

  icache_line_unpacker #(
    .XLEN       (XLEN),
    .ILEN       (ILEN),
    .LINE_INSTR (LI)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .line_valid_i  (line_valid),
    .line_ready_o  (line_ready),
    .line_pc_i     (line_pc),
    .line_data_i   (line_data),
    .flush_i       (flush),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .pc_o          (pc)
`ifdef ICACHE_UNPACK_PERF_CNT_EN
    ,
    .instr_cnt_o   (instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [XLEN+ILEN-1:0] sb[$];
  int pass_cnt = 0;
  int total    = 0;
  int n_fired  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [LI*ILEN-1:0] make_line(input logic [31:0] seed);
    logic [LI*ILEN-1:0] d;
    for (int k = 0; k < LI; k++) d[k*ILEN +: ILEN] = seed + 32'(k);
    return d;
  endfunction

  // Observe handshakes mid-cycle: pop/compare emitted words, push words of captured lines
  task automatic monitor();
    logic [XLEN+ILEN-1:0] e;
    logic [XLEN-1:0] base;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (instr_valid && instr_ready) begin
        n_fired++;
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_instr", 64'(instr), 64'(e[ILEN-1:0]));
          chk("sb_pc", pc, e[XLEN+ILEN-1:ILEN]);
        end
      end
      if (line_valid && line_ready) begin
        base = line_pc & ~64'h7F;
        for (int k = int'(line_pc[6:2]); k < LI; k++) begin
          sb.push_back({base + 64'(k * 4), line_data[k*ILEN +: ILEN]});
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit took;
    int cycles;
    logic [ILEN-1:0] saved_i;
    logic [XLEN-1:0] saved_pc;

    rst = 1'b1; line_valid = 1'b0; line_pc = '0; line_data = '0;
    flush = 1'b0; instr_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'h13);
    chk("rst_pc", pc, 64'd0);
    chk("rst_line_ready", 64'(line_ready), 64'd1);

    // Full line from word 0
    line_pc = 64'h1000; line_data = make_line(32'h0); line_valid = 1'b1; instr_ready = 1'b1;
    n_fired = 0;
    cyc();
    line_valid = 1'b0;
    chk("full_first_valid", 64'(instr_valid), 64'd1);
    chk("full_first_instr", 64'(instr), 64'h0);
    chk("full_first_pc", pc, 64'h1000);
    repeat (32) cyc();
    chk("full_count", 64'(n_fired), 64'd32);
    chk("full_done_valid", 64'(instr_valid), 64'd0);
`ifdef ICACHE_UNPACK_PERF_CNT_EN
    chk("perf_cnt_32", 64'(instr_cnt), 64'd32);
`endif

    // Line entered mid-line near its end
    line_pc = 64'h1078; line_data = make_line(32'h100); line_valid = 1'b1;
    cyc();
    line_valid = 1'b0;
    chk("mid_first_instr", 64'(instr), 64'h11E);
    chk("mid_first_pc", pc, 64'h1078);
    n_fired = 0;
    repeat (3) cyc();
    chk("mid_count", 64'(n_fired), 64'd2);
    chk("mid_done_valid", 64'(instr_valid), 64'd0);

    // Three lines back-to-back with decode stalled
    instr_ready = 1'b0; line_valid = 1'b1;
    line_pc = 64'h2000; line_data = make_line(32'h200); cyc();
    line_pc = 64'h2080; line_data = make_line(32'h300); cyc();
    line_pc = 64'h2100; line_data = make_line(32'h400);
    chk("bb_full_ready", 64'(line_ready), 64'd0);
    cyc();
    chk("bb_still_full", 64'(line_ready), 64'd0);
    chk("bb_head_instr", 64'(instr), 64'h200);
    instr_ready = 1'b1; n_fired = 0; cycles = 0;
    while (n_fired < 96 && cycles < 300) begin
      took = line_valid && line_ready;
      cyc();
      cycles++;
      if (took) line_valid = 1'b0;
    end
    chk("bb_count", 64'(n_fired), 64'd96);
    chk("bb_no_gap_cycles", 64'(cycles), 64'd96);
    chk("bb_done_valid", 64'(instr_valid), 64'd0);

    // Decode ready toggling every cycle
    instr_ready = 1'b0;
    line_pc = 64'h3000; line_data = make_line(32'h500); line_valid = 1'b1;
    cyc();
    line_valid = 1'b0; n_fired = 0;
    for (int i = 0; i < 64; i++) begin
      saved_i = instr; saved_pc = pc;
      instr_ready = (i % 2 == 0);
      cyc();
      if (!instr_ready) begin
        chk("stall_hold_instr", 64'(instr), 64'(saved_i));
        chk("stall_hold_pc", pc, saved_pc);
      end
    end
    chk("toggle_count", 64'(n_fired), 64'd32);
    chk("toggle_done_valid", 64'(instr_valid), 64'd0);

    // Flush at word 5 with the backup slot occupied
    instr_ready = 1'b0; line_valid = 1'b1;
    line_pc = 64'h4000; line_data = make_line(32'h600); cyc();
    line_pc = 64'h5000; line_data = make_line(32'h700); cyc();
    line_valid = 1'b0; instr_ready = 1'b1;
    repeat (5) cyc();
    chk("pre_flush_instr", 64'(instr), 64'h605);
    chk("pre_flush_pc", pc, 64'h4014);
    instr_ready = 1'b0; flush = 1'b1;
    line_pc = 64'h6000; line_data = make_line(32'hA00); line_valid = 1'b1;
    #1;
    chk("flush_line_ready", 64'(line_ready), 64'd0);
    cyc();
    flush = 1'b0; line_valid = 1'b0;
    chk("flush_valid", 64'(instr_valid), 64'd0);
    cyc();
    chk("flush_no_capture", 64'(instr_valid), 64'd0);
    line_pc = 64'h2000; line_data = make_line(32'h800); line_valid = 1'b1;
    cyc();
    line_valid = 1'b0;
    chk("post_flush_instr", 64'(instr), 64'h800);
    chk("post_flush_pc", pc, 64'h2000);
    instr_ready = 1'b1; n_fired = 0;
    repeat (32) cyc();
    chk("post_flush_count", 64'(n_fired), 64'd32);
    chk("post_flush_done", 64'(instr_valid), 64'd0);

    // Reset in the middle of a line with a second line buffered
    instr_ready = 1'b1; line_valid = 1'b1;
    line_pc = 64'h1000; line_data = make_line(32'h900); cyc();
    line_pc = 64'h1080; line_data = make_line(32'hB00); cyc();
    line_valid = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(instr_valid), 64'd0);
    chk("mid_rst_instr", 64'(instr), 64'h13);
    chk("mid_rst_pc", pc, 64'd0);
    chk("mid_rst_line_ready", 64'(line_ready), 64'd1);
`ifdef ICACHE_UNPACK_PERF_CNT_EN
    chk("perf_cnt_rst", 64'(instr_cnt), 64'd0);
`endif
    repeat (3) cyc();
    chk("mid_rst_stays_empty", 64'(instr_valid), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/icache_line_unpacker.md
ICACHE_LINE_UNPACKER -- requirements
Module: icache_line_unpacker

Interface
REQ-001 SHALL have parameter XLEN, default 64, PC width.
REQ-002 SHALL have parameter ILEN, default 32, instruction width.
REQ-003 SHALL have parameter LINE_INSTR, default 32, instructions per I-cache line (power of 2); IDX = log2(LINE_INSTR); LINE_LEN = LINE_INSTR*ILEN.
REQ-004 clk_i  input  1  clock; single clock domain, all state on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 line_valid_i  input  1  I-cache output line valid.
REQ-007 line_ready_o  output  1  unpacker can accept a line this cycle.
REQ-008 line_pc_i  input  XLEN  fetch PC of the line; may point mid-line.
REQ-009 line_data_i  input  LINE_LEN  line data; word k at bits [k*ILEN +: ILEN].
REQ-010 flush_i  input  1  frontend redirect; discard all buffered lines.
REQ-011 instr_valid_o  output  1  instr_o/pc_o valid.
REQ-012 instr_ready_i  input  1  decode accepts instruction.
REQ-013 instr_o  output  ILEN  instruction word.
REQ-014 pc_o  output  XLEN  PC of instr_o.

Function
REQ-015 Line transfer SHALL occur on a cycle with line_valid_i && line_ready_o; instruction transfer on instr_valid_o && instr_ready_i.
REQ-016 SHALL hold two line slots: head (being emitted) and backup; occupancy states EMPTY, ONE, TWO.
REQ-017 On capture, start index SHALL be line_pc_i[OFFSET+IDX-1:OFFSET] (OFFSET = log2(ILEN/8)); line base = line_pc_i with bits [OFFSET+IDX-1:0] cleared.
REQ-018 instr_o SHALL equal head word[idx]; pc_o SHALL equal head base + idx*(ILEN/8); instr_valid_o = 1 iff state != EMPTY.
REQ-019 Outputs SHALL come from registers; line captured at edge N is emitted with instr_valid_o high in cycle N+1 (latency 1, no bubble between consecutive lines).
REQ-020 On instruction transfer with idx != LINE_INSTR-1, idx SHALL increment; with idx == LINE_INSTR-1, head SHALL retire and backup (if present) becomes head.
REQ-021 line_ready_o SHALL be 1 when state != TWO, or when state == TWO and the head's last instruction is being transferred this cycle; line_ready_o SHALL be 0 while flush_i is 1.
REQ-022 Simultaneous head retire and line capture SHALL yield correct ordering: captured line goes to head if state was ONE, to backup if state was TWO; occupancy unchanged.
REQ-023 instr_o/pc_o SHALL stay stable while instr_valid_o && !instr_ready_i.
REQ-024 flush_i SHALL take priority over all transfers: next state EMPTY, no line captured, instr_valid_o = 0 next cycle.
REQ-025 line_data_i/line_pc_i SHALL be ignored when no line transfer occurs.

Reset
REQ-026 On rst_i: state EMPTY, idx 0, instr_valid_o 0, instr_o = NOP (0x13), pc_o 0, line_ready_o 1 from the first cycle after reset deasserts.
REQ-027 Reset mid-emission SHALL discard both slots; no instruction of a pre-reset line is emitted afterwards.

Configuration
REQ-028 Macro ICACHE_UNPACK_PERF_CNT_EN: when defined, SHALL add output instr_cnt_o (32 bits) counting instruction transfers, cleared by rst_i only (not flush_i), wrapping 0xFFFFFFFF->0; when undefined, port and counter SHALL be absent and behaviour otherwise identical.

Verification
REQ-029 Line pc 0x1000, word k = k, instr_ready_i=1 -> 32 instructions 0..31, pc 0x1000..0x107C, one per cycle, first valid the cycle after capture.
REQ-030 Line pc 0x1078 -> exactly two instructions: word 30 @0x1078, word 31 @0x107C, then instr_valid_o=0.
REQ-031 Three lines offered back-to-back, instr_ready_i=0 -> two captured, line_ready_o=0; after releasing ready, all 96 instructions in order with no gap between lines.
REQ-032 instr_ready_i toggling 1/0 per cycle -> instr_o/pc_o held on stall cycles, no duplicate or dropped word.
REQ-033 flush_i at word 5 with backup full -> next cycle instr_valid_o=0; new line pc 0x2000 emits word 0 @0x2000.
REQ-034 With ICACHE_UNPACK_PERF_CNT_EN, after REQ-029 instr_cnt_o = 32; rst_i mid-line -> instr_cnt_o=0, instr_valid_o=0.
